// File: rtl/kp_pkg.sv
// Shared keypad definitions: column ring encoding, key-code width,
// per-frame classification and debounce FSM state types.
package kp_pkg;

  localparam int KEY_W    = 4;
  localparam int NUM_COLS = 4;
  localparam int COL_W    = 2;

  // One-hot active-low column ring; the display anode driver uses the same pattern.
  localparam logic [NUM_COLS-1:0] COL_DRV_0 = 4'b0111;
  localparam logic [NUM_COLS-1:0] COL_DRV_1 = 4'b1011;
  localparam logic [NUM_COLS-1:0] COL_DRV_2 = 4'b1101;
  localparam logic [NUM_COLS-1:0] COL_DRV_3 = 4'b1110;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } cls_e;

  typedef enum logic {
    ST_IDLE,
    ST_HELD
  } state_e;

  // Column index to active-low drive pattern.
  function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
    case (idx)
      2'd0:    col_drive = COL_DRV_0;
      2'd1:    col_drive = COL_DRV_1;
      2'd2:    col_drive = COL_DRV_2;
      default: col_drive = COL_DRV_3;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_D,
  output logic [WIDTH-1:0] o_Q
);

  logic [WIDTH-1:0] meta_p0;

  // Stage 0 may go metastable; stage 1 is the resolved copy used downstream.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      meta_p0 <= RST_VAL;
      o_Q     <= RST_VAL;
    end else begin
      meta_p0 <= i_D;
      o_Q     <= meta_p0;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: drives a column ring, samples the
// rows at the end of each dwell, classifies each 4-column frame and
// debounces the result into one key code per accepted press.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [3:0]       i_Rows,
  output logic [3:0]       o_Cols,
  output logic [1:0]       o_Col_Sel,
  output logic [KEY_W-1:0] o_Key,
  output logic             o_Valid,
  output logic             o_Pressed
);

  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = $clog2(DEBOUNCE + 1);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE);

  // Number of low bits in a row sample.
  function automatic logic [2:0] count_low(input logic [3:0] low);
    count_low = {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [1:0] low_index(input logic [3:0] low);
    if (low[0])      low_index = 2'd0;
    else if (low[1]) low_index = 2'd1;
    else if (low[2]) low_index = 2'd2;
    else             low_index = 2'd3;
  endfunction

  // Frame hit count saturates at 2: anything beyond "more than one" is MULTI.
  function automatic logic [1:0] sat_hits(input logic [1:0] acc, input logic [2:0] add);
    logic [2:0] sum;
    sum = {1'b0, acc} + add;
    sat_hits = (sum >= 3'd2) ? 2'd2 : sum[1:0];
  endfunction

  // Stable-frame counter increment, saturating at DEBOUNCE.
  function automatic logic [STB_W-1:0] sat_inc(input logic [STB_W-1:0] v);
    sat_inc = (v >= STB_MAX) ? STB_MAX : v + 1'b1;
  endfunction

  logic [3:0]       rows_p1;
  logic [PS_W-1:0]  ps_cnt;
  logic [COL_W-1:0] col_sel;
  logic             tc;

  logic [1:0]       acc_hits;
  logic [KEY_W-1:0] acc_code;
  cls_e             prev_cls;
  logic [KEY_W-1:0] prev_code;
  logic [STB_W-1:0] stable;
  state_e           state;
  logic [KEY_W-1:0] key_q;
  logic             valid_q;
  logic             pressed_q;

  logic [3:0]       row_low;
  logic [2:0]       n_low;
  logic [1:0]       frm_hits;
  logic [KEY_W-1:0] frm_code;
  cls_e             frm_cls;
  logic             frm_same;
  logic [STB_W-1:0] stb_nxt;

  sync_2ff #(
    .WIDTH  (4),
    .RST_VAL(4'b1111)
  ) u_row_sync (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .i_D    (i_Rows),
    .o_Q    (rows_p1)
  );

  assign tc = (ps_cnt == PS_LAST);

  // Dwell prescaler and column ring; the column advances on the dwell's last cycle.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      ps_cnt  <= '0;
      col_sel <= '0;
    end else if (tc) begin
      ps_cnt  <= '0;
      col_sel <= col_sel + 1'b1;
    end else begin
      ps_cnt  <= ps_cnt + 1'b1;
    end
  end

  // Fold the current column's sample into the frame and classify it as it would close now.
  always_comb begin
    row_low  = ~rows_p1;
    n_low    = count_low(row_low);
    frm_hits = sat_hits(acc_hits, n_low);
    frm_code = acc_code;
    if (acc_hits == 2'd0 && n_low == 3'd1) frm_code = {col_sel, low_index(row_low)};
    case (frm_hits)
      2'd0:    frm_cls = CLS_NONE;
      2'd1:    frm_cls = CLS_SINGLE;
      default: frm_cls = CLS_MULTI;
    endcase
    frm_same = (frm_cls == prev_cls) && (frm_cls != CLS_SINGLE || frm_code == prev_code);
    if (frm_cls == CLS_MULTI) stb_nxt = '0;
    else if (frm_same)        stb_nxt = sat_inc(stable);
    else                      stb_nxt = STB_W'(1);
  end

  // Frame accumulator and debounce FSM; decisions are taken at the TC of column 3.
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      acc_hits  <= '0;
      acc_code  <= '0;
      prev_cls  <= CLS_NONE;
      prev_code <= '0;
      stable    <= '0;
      state     <= ST_IDLE;
      key_q     <= '0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tc) begin
        if (col_sel != 2'd3) begin
          acc_hits <= frm_hits;
          acc_code <= frm_code;
        end else begin
          acc_hits  <= '0;
          acc_code  <= '0;
          prev_cls  <= frm_cls;
          prev_code <= frm_code;
          stable    <= stb_nxt;
          if (frm_cls != CLS_MULTI && stb_nxt == STB_MAX) begin
            case (state)
              ST_IDLE: begin
                if (frm_cls == CLS_SINGLE) begin
                  state     <= ST_HELD;
                  key_q     <= frm_code;
                  pressed_q <= 1'b1;
                  valid_q   <= 1'b1;
                end
              end
              default: begin
                if (frm_cls == CLS_NONE) begin
                  state     <= ST_IDLE;
                  pressed_q <= 1'b0;
                end else if (frm_code != key_q) begin
                  key_q   <= frm_code;
                  valid_q <= 1'b1;
                end
              end
            endcase
          end
        end
      end
    end
  end

  assign o_Cols    = col_drive(col_sel);
  assign o_Col_Sel = col_sel;
  assign o_Key     = key_q;
  assign o_Valid   = valid_q;
  assign o_Pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (16-cycle frames).
// A keypad model closes row/column contacts; accepted keys are scoreboarded.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [1:0] col_sel;
  logic [3:0] key;
  logic       valid;
  logic       pressed;

  logic [15:0] keys;        // bit 4*c+r closes column c to row r
  int          cyc;         // posedges since the last reset release
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  exp_q[$];
  logic        valid_d = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .i_Clk    (clk),
    .i_Reset  (rst_n),
    .i_Rows   (rows),
    .o_Cols   (cols),
    .o_Col_Sel(col_sel),
    .o_Key    (key),
    .o_Valid  (valid),
    .o_Pressed(pressed)
  );

  // Passive matrix: a row reads low when a closed key sits on the driven column.
  always_comb begin
    rows = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[4*c+r] && !cols[3-c]) rows[r] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [3:0] ring(input int c);
    case (c)
      0:       ring = 4'b0111;
      1:       ring = 4'b1011;
      2:       ring = 4'b1101;
      default: ring = 4'b1110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every o_Valid pulse must match the oldest expected key.
  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if (valid_d) begin
        errors++;
        $display("FAIL valid_back_to_back: got 2 consecutive pulses expected 1");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got key %0d expected no pulse", key);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (key !== e) begin
          errors++;
          $display("FAIL valid_key: got %0d expected %0d", key, e);
        end
      end
    end
    valid_d <= valid;
  end

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (cyc % 16 == ph) return;
    end
    check("wait_phase_timeout", 1, 0);
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    keys  = '0;
    repeat (3) @(negedge clk);
    check("rst_cols", cols, 4'b0111);
    check("rst_col_sel", col_sel, 0);
    check("rst_key", key, 0);
    check("rst_valid", valid, 0);
    check("rst_pressed", pressed, 0);
    rst_n = 1'b1;

    // Idle scan: ring pattern, no presses.
    for (int k = 0; k < 64; k++) begin
      if (k % 4 == 2) begin
        check("idle_cols", cols, ring((k / 4) % 4));
        check("idle_col_sel", col_sel, (k / 4) % 4);
      end
      @(negedge clk);
    end
    check("idle_pressed", pressed, 0);

    // Press col 2 row 1 -> code 9.
    keys[9] = 1'b1;
    exp_q.push_back(4'd9);
    repeat (52) @(negedge clk);
    check_drained("press9_pulse");
    check("press9_key", key, 9);
    check("press9_pressed", pressed, 1);
    repeat (160) @(negedge clk);
    check("hold9_pressed", pressed, 1);

    // Release.
    keys = '0;
    repeat (52) @(negedge clk);
    check("rel9_pressed", pressed, 0);
    check("rel9_key", key, 9);

    // Bounce key 3 (col 0 row 3) once per frame, away from its sample point.
    wait_phase(8);
    for (int t = 0; t < 6; t++) begin
      keys[3] = ~keys[3];
      repeat (16) @(negedge clk);
      check("bounce_pressed", pressed, 0);
    end
    check("bounce_key", key, 9);
    keys[3] = 1'b1;
    exp_q.push_back(4'd3);
    repeat (52) @(negedge clk);
    check_drained("press3_pulse");
    check("press3_key", key, 3);
    check("press3_pressed", pressed, 1);
    keys = '0;
    repeat (52) @(negedge clk);
    check("rel3_pressed", pressed, 0);

    // Chord: col 1 row 0 (4) and col 3 row 2 (14).
    keys[4]  = 1'b1;
    keys[14] = 1'b1;
    repeat (64) @(negedge clk);
    check("multi_pressed", pressed, 0);
    check("multi_key", key, 3);
    keys[14] = 1'b0;
    exp_q.push_back(4'd4);
    repeat (52) @(negedge clk);
    check_drained("press4_pulse");
    check("press4_key", key, 4);
    check("press4_pressed", pressed, 1);

    // Async reset in the middle of column 2's dwell while held.
    wait_phase(9);
    check("pre_rst_col_sel", col_sel, 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cols", cols, 4'b0111);
    check("arst_col_sel", col_sel, 0);
    check("arst_key", key, 0);
    check("arst_pressed", pressed, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'd4);   // key 4 still held: re-accepted after restart
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 1) check("restart_cols", cols, ring(k / 4));
      @(negedge clk);
    end
    repeat (52) @(negedge clk);
    check_drained("rearm4_pulse");
    check("rearm4_key", key, 4);
    keys = '0;
    repeat (52) @(negedge clk);
    check("final_pressed", pressed, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
